// File: rtl/icache_mem_responder_pkg.sv
// Refill-port types and cache geometry shared by the instruction-cache memory responder.
// The cache line width is 64 bits with a 3-bit byte offset, and addresses are 64-bit physical.
package icache_mem_responder_pkg;

    localparam int unsigned ICACHE_LINE_WIDTH   = 64;
    localparam int unsigned ICACHE_OFFSET_WIDTH = 3;
    localparam int unsigned PLEN                = 64;

    typedef struct packed {
        logic            req;
        logic [PLEN-1:0] paddr;
    } mem_req_t;

    typedef struct packed {
        logic                         ready;
        logic [ICACHE_LINE_WIDTH-1:0] data;
    } mem_rsp_t;

endpackage

// File: rtl/icache_mem_responder_sram.sv
// Single-port line-wide backing store with a registered read port.
// The contents are never reset, so a preload survives a responder reset.
module icache_mem_responder_sram #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned NUM_WORDS  = 256
) (
    input  logic                         clk_i,
    input  logic                         req_i,
    input  logic                         we_i,
    input  logic [$clog2(NUM_WORDS)-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0]        wdata_i,
    output logic [DATA_WIDTH-1:0]        rdata_o
);

    logic [DATA_WIDTH-1:0] mem_r [NUM_WORDS];
    logic [DATA_WIDTH-1:0] rdata_r;

    // Write or read one line per request; rdata holds until the next read.
    always_ff @(posedge clk_i) begin
        if (req_i && we_i) begin
            mem_r[addr_i] <= wdata_i;
        end else if (req_i) begin
            rdata_r <= mem_r[addr_i];
        end
    end

    assign rdata_o = rdata_r;

endmodule

// File: rtl/icache_mem_responder.sv
// Refill responder: prefetches the line at the current paddr after LATENCY cycles
// and presents it with ready until the cache handshakes with req.
module icache_mem_responder
    import icache_mem_responder_pkg::*;
#(
    parameter int unsigned LATENCY   = 4,
    parameter int unsigned MEM_LINES = 256
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  mem_req_t                     mreq_i,
    output mem_rsp_t                     mreq_o,
    input  logic                         init_we_i,
    input  logic [$clog2(MEM_LINES)-1:0] init_addr_i,
    input  logic [ICACHE_LINE_WIDTH-1:0] init_data_i,
    output logic [31:0]                  served_cnt_o,
    output logic                         proto_err_o
);

    localparam int unsigned IDX_W    = $clog2(MEM_LINES);
    localparam logic [7:0]  LAT_INIT = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e                       state_r;
    logic [PLEN-1:0]              addr_r;
    logic [7:0]                   lat_cnt_r;
    logic [ICACHE_LINE_WIDTH-1:0] data_r;
    logic                         ready_r;
    logic [31:0]                  served_cnt_r;
    logic                         proto_err_r;

    logic                         addr_chg_s;
    logic                         read_issue_s;
    logic                         sram_req_s;
    logic [IDX_W-1:0]             rd_idx_s;
    logic [IDX_W-1:0]             sram_addr_s;
    logic [ICACHE_LINE_WIDTH-1:0] sram_rdata_s;

    // Read issue and port arbitration; a preload write always owns the SRAM port.
    always_comb begin
        addr_chg_s   = (mreq_i.paddr != addr_r);
        rd_idx_s     = addr_r[IDX_W+ICACHE_OFFSET_WIDTH-1 -: IDX_W];
        read_issue_s = (state_r == FETCH) && !addr_chg_s &&
                       (lat_cnt_r == 8'd0) && !init_we_i;
        sram_req_s   = init_we_i | read_issue_s;
        if (init_we_i) begin
            sram_addr_s = init_addr_i;
        end else begin
            sram_addr_s = rd_idx_s;
        end
    end

    icache_mem_responder_sram #(
        .DATA_WIDTH (ICACHE_LINE_WIDTH),
        .NUM_WORDS  (MEM_LINES)
    ) u_sram (
        .clk_i   (clk_i),
        .req_i   (sram_req_s),
        .we_i    (init_we_i),
        .addr_i  (sram_addr_s),
        .wdata_i (init_data_i),
        .rdata_o (sram_rdata_s)
    );

    // Fetch FSM with registered ready, handshake counter and sticky protocol error.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r      <= IDLE;
            addr_r       <= '0;
            lat_cnt_r    <= 8'd0;
            data_r       <= '0;
            ready_r      <= 1'b0;
            served_cnt_r <= 32'd0;
            proto_err_r  <= 1'b0;
        end else begin
            if (mreq_i.req && !ready_r) begin
                proto_err_r <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    addr_r    <= mreq_i.paddr;
                    lat_cnt_r <= LAT_INIT;
                    state_r   <= FETCH;
                end
                FETCH: begin
                    if (addr_chg_s) begin
                        addr_r    <= mreq_i.paddr;
                        lat_cnt_r <= LAT_INIT;
                    end else if (lat_cnt_r != 8'd0) begin
                        lat_cnt_r <= lat_cnt_r - 8'd1;
                    end else if (!init_we_i) begin
                        state_r <= LOAD;
                    end
                end
                LOAD: begin
                    if (addr_chg_s) begin
                        addr_r    <= mreq_i.paddr;
                        lat_cnt_r <= LAT_INIT;
                        state_r   <= FETCH;
                    end else begin
                        data_r  <= sram_rdata_s;
                        ready_r <= 1'b1;
                        state_r <= RESP;
                    end
                end
                RESP: begin
                    // A handshake wins over an address change in the same cycle.
                    if (mreq_i.req) begin
                        served_cnt_r <= served_cnt_r + 32'd1;
                        ready_r      <= 1'b0;
                        state_r      <= IDLE;
                    end else if (addr_chg_s) begin
                        addr_r    <= mreq_i.paddr;
                        lat_cnt_r <= LAT_INIT;
                        ready_r   <= 1'b0;
                        state_r   <= FETCH;
                    end
                end
                default: begin
                    ready_r <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign mreq_o.ready = ready_r;
    assign mreq_o.data  = data_r;
    assign served_cnt_o = served_cnt_r;
    assign proto_err_o  = proto_err_r;

endmodule

// File: tb/tb_icache_mem_responder.sv
// Directed bench for icache_mem_responder with LATENCY=4 and 256 lines; every
// expected value below is hand-computed from the cycle timing of the responder.
module tb_icache_mem_responder;
    import icache_mem_responder_pkg::*;

    localparam logic [63:0] L5  = 64'hDEAD_BEEF_0000_0005;
    localparam logic [63:0] L6  = 64'hCAFE_F00D_0000_0006;
    localparam logic [63:0] L7  = 64'h1234_5678_0000_0007;
    localparam logic [63:0] L7N = 64'hA5A5_5A5A_0000_0077;
    localparam logic [63:0] L5N = 64'h0BAD_0BAD_0000_0055;

    logic        clk = 1'b0;
    logic        rst_n;
    mem_req_t    mreq;
    mem_rsp_t    mrsp;
    logic        init_we;
    logic [7:0]  init_addr;
    logic [63:0] init_data;
    logic [31:0] served_cnt;
    logic        proto_err;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    icache_mem_responder #(
        .LATENCY   (4),
        .MEM_LINES (256)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .mreq_i       (mreq),
        .mreq_o       (mrsp),
        .init_we_i    (init_we),
        .init_addr_i  (init_addr),
        .init_data_i  (init_data),
        .served_cnt_o (served_cnt),
        .proto_err_o  (proto_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_line(input logic [7:0] a, input logic [63:0] d);
        init_we   = 1'b1;
        init_addr = a;
        init_data = d;
        step(1);
        init_we   = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (mrsp.ready !== 1'b1 && k < 20) begin
            step(1);
            k++;
        end
        chk(tag, 64'(mrsp.ready), 64'd1);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw;
        logic bad;

        rst_n     = 1'b0;
        mreq      = '0;
        init_we   = 1'b0;
        init_addr = 8'd0;
        init_data = 64'd0;
        step(2);
        chk("reset ready",  64'(mrsp.ready),  64'd0);
        chk("reset data",   mrsp.data,        64'd0);
        chk("reset count",  64'(served_cnt),  64'd0);
        chk("reset err",    64'(proto_err),   64'd0);

        write_line(8'd5, L5);
        write_line(8'd6, L6);
        write_line(8'd7, L7);

        // Basic fetch of line 5: IDLE cycle, 4 FETCH, LOAD, then RESP.
        mreq.paddr = 64'h28;
        rst_n      = 1'b1;
        step(5);
        chk("t1 ready before latency", 64'(mrsp.ready), 64'd0);
        step(1);
        chk("t1 ready at latency", 64'(mrsp.ready), 64'd1);
        chk("t1 data",             mrsp.data,       L5);
        chk("t1 count before",     64'(served_cnt), 64'd0);
        mreq.req = 1'b1;
        step(1);
        mreq.req = 1'b0;
        chk("t1 count after", 64'(served_cnt), 64'd1);
        chk("t1 ready drop",  64'(mrsp.ready), 64'd0);
        chk("t1 err clear",   64'(proto_err),  64'd0);

        // Address change in the second FETCH cycle restarts towards line 6.
        step(2);
        mreq.paddr = 64'h30;
        saw = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (mrsp.ready === 1'b1) saw = 1'b1;
        end
        chk("t2 no early ready", 64'(saw), 64'd0);
        step(1);
        chk("t2 ready", 64'(mrsp.ready), 64'd1);
        chk("t2 data",  mrsp.data,       L6);

        // Hold in RESP for 50 cycles without req.
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (mrsp.ready !== 1'b1 || mrsp.data !== L6) bad = 1'b1;
        end
        chk("t3 hold stable", 64'(bad), 64'd0);
        mreq.req = 1'b1;
        step(1);
        mreq.req = 1'b0;
        chk("t3 count", 64'(served_cnt), 64'd2);
        step(3);
        chk("t3 single increment", 64'(served_cnt), 64'd2);
        chk("t3 ready low",        64'(mrsp.ready), 64'd0);

        // req while ready is low is a protocol error and is otherwise ignored.
        chk("t4 err before", 64'(proto_err), 64'd0);
        mreq.req = 1'b1;
        step(1);
        mreq.req = 1'b0;
        chk("t4 err set",        64'(proto_err),  64'd1);
        chk("t4 count unchanged", 64'(served_cnt), 64'd2);
        wait_ready("t4 refill ready");
        chk("t4 data",     mrsp.data,      L6);
        chk("t4 err sticky", 64'(proto_err), 64'd1);

        // Preload writes during the final FETCH cycle defer the read by one cycle each.
        mreq.req = 1'b1;
        step(1);
        mreq.req   = 1'b0;
        mreq.paddr = 64'h38;
        chk("t5 count", 64'(served_cnt), 64'd3);
        step(4);
        init_we   = 1'b1;
        init_addr = 8'd7;
        init_data = L7N;
        step(1);
        chk("t5 deferred 1", 64'(mrsp.ready), 64'd0);
        step(1);
        init_we = 1'b0;
        chk("t5 deferred 2", 64'(mrsp.ready), 64'd0);
        step(1);
        chk("t5 load cycle", 64'(mrsp.ready), 64'd0);
        step(1);
        chk("t5 ready", 64'(mrsp.ready), 64'd1);
        chk("t5 data",  mrsp.data,       L7N);

        // Reset during LOAD; an aliased paddr then refetches line 5 from the kept SRAM.
        mreq.req = 1'b1;
        step(1);
        mreq.req   = 1'b0;
        mreq.paddr = 64'h1_0000_0028;
        chk("t6 count before reset", 64'(served_cnt), 64'd4);
        step(5);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        chk("t6 reset ready", 64'(mrsp.ready), 64'd0);
        chk("t6 reset count", 64'(served_cnt), 64'd0);
        chk("t6 reset err",   64'(proto_err),  64'd0);
        chk("t6 reset data",  mrsp.data,       64'd0);
        step(5);
        chk("t6 ready before latency", 64'(mrsp.ready), 64'd0);
        step(1);
        chk("t6 ready", 64'(mrsp.ready), 64'd1);
        chk("t6 alias data", mrsp.data,  L5);

        // A write to the held line leaves the presented data stale until refetch.
        write_line(8'd5, L5N);
        chk("t7 stale data",  mrsp.data,       L5);
        chk("t7 ready held",  64'(mrsp.ready), 64'd1);
        mreq.req = 1'b1;
        step(1);
        mreq.req = 1'b0;
        chk("t7 count", 64'(served_cnt), 64'd1);
        wait_ready("t7 refetch ready");
        chk("t7 new data", mrsp.data, L5N);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
